// File: rtl/dptr_ctrl_if.sv
// Bus between the DPTR sequencer and its instruction memory / register file.
// master: the sequencer side; slave: memory, register file and launch control.
interface dptr_ctrl_if #(
    parameter int PC_W = 8
);
    logic            start;
    logic [PC_W-1:0] imem_addr;
    logic [31:0]     imem_data;
    logic [4:0]      rf_ra1;
    logic [4:0]      rf_ra2;
    logic [4:0]      rf_wa;
    logic            rf_we;
    logic [2:0]      alu_sel;
    logic            busy;
    logic            done;
    logic            err;
    logic [15:0]     retired;

    modport master (
        input  start, imem_data,
        output imem_addr, rf_ra1, rf_ra2, rf_wa, rf_we, alu_sel,
               busy, done, err, retired
    );

    modport slave (
        output start, imem_data,
        input  imem_addr, rf_ra1, rf_ra2, rf_wa, rf_we, alu_sel,
               busy, done, err, retired
    );
endinterface

// File: rtl/dptr_ctrl.sv
// dptr_ctrl: four-cycle-per-instruction sequencer for the R-type datapath.
// Runs instructions 0..LAST_ADDR (FETCH/DECODE/EXEC/WB each), then pulses done.
// Optional feature macro: DPTR_CTRL_SLT_EN -- when defined, funct 101010 (slt)
// is legal and selects ALU op 111; otherwise slt is an illegal instruction.
module dptr_ctrl #(
    parameter int PC_W      = 8,
    parameter int LAST_ADDR = 15
) (
    input  logic        clk,
    input  logic        rst,
    dptr_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_DONE
    } state_t;

    // Decode result, captured once in DECODE so EXEC/WB never look at imem.
    typedef struct packed {
        logic       legal;
        logic       wr;
        logic [2:0] alu;
    } dec_t;

    localparam logic [PC_W-1:0] LAST_PC  = PC_W'(LAST_ADDR);
    localparam logic [5:0]      OP_RTYPE = 6'b000000;
    localparam logic [5:0]      F_ADD    = 6'b100000;
    localparam logic [5:0]      F_SUB    = 6'b100010;
    localparam logic [5:0]      F_AND    = 6'b100100;
    localparam logic [5:0]      F_OR     = 6'b100101;
    localparam logic [5:0]      F_SLT    = 6'b101010;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q;
    logic [31:0]     ir_q;
    dec_t            dec_q;
    logic            err_q;
    logic [15:0]     retired_q;

    logic [4:0]      ra1_o, ra2_o, wa_o;
    logic            we_o;
    logic [2:0]      alu_o;
    logic            err_o;

    // An all-zero word is a NOP: legal, retired, but never writes.
    // Illegal encodings decode to alu 000 so no stray op code leaks out.
    function automatic dec_t decode(input logic [31:0] ir);
        dec_t d;
        d = '0;
        if (ir == 32'h0) begin
            d.legal = 1'b1;
        end else if (ir[31:26] == OP_RTYPE) begin
            case (ir[5:0])
                F_ADD:   d = '{legal: 1'b1, wr: 1'b1, alu: 3'b010};
                F_SUB:   d = '{legal: 1'b1, wr: 1'b1, alu: 3'b110};
                F_AND:   d = '{legal: 1'b1, wr: 1'b1, alu: 3'b000};
                F_OR:    d = '{legal: 1'b1, wr: 1'b1, alu: 3'b001};
`ifdef DPTR_CTRL_SLT_EN
                F_SLT:   d = '{legal: 1'b1, wr: 1'b1, alu: 3'b111};
`endif
                default: d = '0;
            endcase
        end
        return d;
    endfunction

    // State register; reset wins from any state.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic: start only matters in IDLE, so it is ignored while busy.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (bus.start) state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC:   state_d = dec_q.legal ? S_WB : S_DONE;
            S_WB:     state_d = (pc_q == LAST_PC) ? S_DONE : S_FETCH;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath registers: PC, IR, latched decode, sticky error, retire counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= '0;
            ir_q      <= '0;
            dec_q     <= '0;
            err_q     <= 1'b0;
            retired_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        pc_q      <= '0;
                        err_q     <= 1'b0;
                        retired_q <= '0;
                    end
                end
                S_FETCH:  ir_q  <= bus.imem_data;
                S_DECODE: dec_q <= decode(ir_q);
                S_EXEC:   if (!dec_q.legal) err_q <= 1'b1;
                S_WB: begin
                    if (retired_q != 16'hFFFF) retired_q <= retired_q + 16'd1;
                    // Stop at LAST_PC instead of incrementing, so PC never wraps.
                    if (pc_q != LAST_PC) pc_q <= pc_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Output decode from state and IR/decode registers only (no imem_data path).
    always_comb begin
        ra1_o = '0;
        ra2_o = '0;
        wa_o  = '0;
        we_o  = 1'b0;
        alu_o = '0;
        err_o = err_q;
        case (state_q)
            S_DECODE: begin
                ra1_o = ir_q[25:21];
                ra2_o = ir_q[20:16];
            end
            S_EXEC: begin
                ra1_o = ir_q[25:21];
                ra2_o = ir_q[20:16];
                alu_o = dec_q.alu;
                // Flag the illegal instruction in its own EXEC cycle.
                err_o = err_q | ~dec_q.legal;
            end
            S_WB: begin
                ra1_o = ir_q[25:21];
                ra2_o = ir_q[20:16];
                alu_o = dec_q.alu;
                wa_o  = ir_q[15:11];
                we_o  = dec_q.wr && (ir_q[15:11] != 5'd0);
            end
            default: ;
        endcase
    end

    assign bus.imem_addr = pc_q;
    assign bus.rf_ra1    = ra1_o;
    assign bus.rf_ra2    = ra2_o;
    assign bus.rf_wa     = wa_o;
    assign bus.rf_we     = we_o;
    assign bus.alu_sel   = alu_o;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.err       = err_o;
    assign bus.retired   = retired_q;

endmodule

// File: tb/tb_dptr_ctrl.sv
// Directed bench for dptr_ctrl with LAST_ADDR=2 (three-instruction programs).
// Cycle numbering: the edge that samples start is edge t; cycle 1 is t+1.
module tb_dptr_ctrl;

    logic clk;
    logic rst;
    logic [31:0] mem [256];

    dptr_ctrl_if #(.PC_W(8)) bus ();

    dptr_ctrl #(.PC_W(8), .LAST_ADDR(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.imem_data = mem[bus.imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Per-cycle capture of one run
    logic [4:0]  ra1_c  [64];
    logic [4:0]  ra2_c  [64];
    logic [2:0]  alu_c  [64];
    logic        err_c  [64];
    logic        busy_c [64];
    logic [7:0]  addr_c [64];
    int          n_we, n_done, done_cyc;
    int          we_cyc [8];
    logic [4:0]  we_wa  [8];
    logic [2:0]  we_alu [8];

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, 5'b00000, fn};
    endfunction

    // Pulse (or hold) start and capture outputs each cycle until two cycles past done.
    task automatic run(input bit hold);
        int last;
        last = 40;
        n_we = 0; n_done = 0; done_cyc = -1;
        for (int i = 0; i < 64; i++) begin
            ra1_c[i] = '0; ra2_c[i] = '0; alu_c[i] = '0;
            err_c[i] = 1'b0; busy_c[i] = 1'b0; addr_c[i] = '0;
        end
        @(negedge clk); bus.start = 1'b1;
        @(posedge clk); #1;
        if (!hold) bus.start = 1'b0;
        for (int c = 1; c <= last && c < 64; c++) begin
            ra1_c[c] = bus.rf_ra1; ra2_c[c] = bus.rf_ra2; alu_c[c] = bus.alu_sel;
            err_c[c] = bus.err; busy_c[c] = bus.busy; addr_c[c] = bus.imem_addr;
            if (bus.rf_we && n_we < 8) begin
                we_cyc[n_we] = c; we_wa[n_we] = bus.rf_wa; we_alu[n_we] = bus.alu_sel;
                n_we++;
            end
            if (bus.done) begin
                n_done++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    last = c + 2;
                end
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
        end
        if (done_cyc < 0) begin
            errors++;
            $display("FAIL run_timeout: no done within 40 cycles");
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.done); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", bus.err); end
        checks++; if (bus.retired !== 16'd0) begin errors++; $display("FAIL reset_retired got %0d exp 0", bus.retired); end
        checks++; if (bus.imem_addr !== 8'd0) begin errors++; $display("FAIL reset_addr got %0d exp 0", bus.imem_addr); end
        checks++; if ({bus.rf_we, bus.rf_ra1, bus.rf_ra2, bus.rf_wa, bus.alu_sel} !== 19'd0) begin
            errors++; $display("FAIL reset_rf got we=%b ra1=%0d ra2=%0d wa=%0d alu=%b exp all 0",
                               bus.rf_we, bus.rf_ra1, bus.rf_ra2, bus.rf_wa, bus.alu_sel);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic load_basic;
        mem[0] = rtype(5'd1, 5'd2, 5'd3, 6'b100000); // add $3,$1,$2
        mem[1] = rtype(5'd3, 5'd1, 5'd4, 6'b100010); // sub $4,$3,$1
        mem[2] = rtype(5'd4, 5'd2, 5'd5, 6'b100101); // or  $5,$4,$2
    endtask

    task automatic test_basic;
        load_basic();
        run(1'b0);
        checks++; if (addr_c[1] !== 8'd0 || busy_c[1] !== 1'b1) begin errors++; $display("FAIL basic_fetch0 got addr=%0d busy=%b exp 0/1", addr_c[1], busy_c[1]); end
        checks++; if (ra1_c[2] !== 5'd1 || ra2_c[2] !== 5'd2) begin errors++; $display("FAIL basic_ra_dec0 got %0d/%0d exp 1/2", ra1_c[2], ra2_c[2]); end
        checks++; if (ra1_c[6] !== 5'd3 || ra2_c[6] !== 5'd1) begin errors++; $display("FAIL basic_ra_dec1 got %0d/%0d exp 3/1", ra1_c[6], ra2_c[6]); end
        checks++; if (n_we !== 3) begin errors++; $display("FAIL basic_nwe got %0d exp 3", n_we); end
        checks++; if (we_cyc[0] !== 4 || we_wa[0] !== 5'd3 || we_alu[0] !== 3'b010) begin errors++; $display("FAIL basic_we0 got cyc=%0d wa=%0d alu=%b exp 4/3/010", we_cyc[0], we_wa[0], we_alu[0]); end
        checks++; if (we_cyc[1] !== 8 || we_wa[1] !== 5'd4 || we_alu[1] !== 3'b110) begin errors++; $display("FAIL basic_we1 got cyc=%0d wa=%0d alu=%b exp 8/4/110", we_cyc[1], we_wa[1], we_alu[1]); end
        checks++; if (we_cyc[2] !== 12 || we_wa[2] !== 5'd5 || we_alu[2] !== 3'b001) begin errors++; $display("FAIL basic_we2 got cyc=%0d wa=%0d alu=%b exp 12/5/001", we_cyc[2], we_wa[2], we_alu[2]); end
        checks++; if (done_cyc !== 13 || n_done !== 1) begin errors++; $display("FAIL basic_done got cyc=%0d n=%0d exp 13/1", done_cyc, n_done); end
        checks++; if (bus.retired !== 16'd3 || bus.err !== 1'b0) begin errors++; $display("FAIL basic_final got retired=%0d err=%b exp 3/0", bus.retired, bus.err); end
        checks++; if (busy_c[14] !== 1'b0 || addr_c[14] !== 8'd2) begin errors++; $display("FAIL basic_idle got busy=%b addr=%0d exp 0/2", busy_c[14], addr_c[14]); end
    endtask

    task automatic test_nop_r0;
        mem[0] = rtype(5'd1, 5'd2, 5'd0, 6'b100000); // add $0,$1,$2
        mem[1] = 32'h0000_0000;                      // nop
        mem[2] = rtype(5'd1, 5'd2, 5'd7, 6'b100100); // and $7,$1,$2
        run(1'b0);
        checks++; if (n_we !== 1 || we_cyc[0] !== 12 || we_wa[0] !== 5'd7 || we_alu[0] !== 3'b000) begin
            errors++; $display("FAIL nop_we got n=%0d cyc=%0d wa=%0d alu=%b exp 1/12/7/000", n_we, we_cyc[0], we_wa[0], we_alu[0]);
        end
        checks++; if (alu_c[8] !== 3'b000) begin errors++; $display("FAIL nop_alu got %b exp 000", alu_c[8]); end
        checks++; if (bus.retired !== 16'd3 || done_cyc !== 13) begin errors++; $display("FAIL nop_final got retired=%0d done=%0d exp 3/13", bus.retired, done_cyc); end
    endtask

    task automatic test_illegal;
        mem[0] = rtype(5'd4, 5'd2, 5'd5, 6'b100101);      // or $5,$4,$2
        mem[1] = {6'b100011, 5'd1, 5'd2, 16'h0004};       // lw: illegal here
        mem[2] = rtype(5'd1, 5'd2, 5'd3, 6'b100000);
        run(1'b0);
        checks++; if (err_c[6] !== 1'b0 || err_c[7] !== 1'b1 || err_c[8] !== 1'b1) begin
            errors++; $display("FAIL illegal_err got c6=%b c7=%b c8=%b exp 0/1/1", err_c[6], err_c[7], err_c[8]);
        end
        checks++; if (done_cyc !== 8 || n_done !== 1) begin errors++; $display("FAIL illegal_done got cyc=%0d n=%0d exp 8/1", done_cyc, n_done); end
        checks++; if (n_we !== 1 || we_cyc[0] !== 4) begin errors++; $display("FAIL illegal_we got n=%0d cyc0=%0d exp 1/4", n_we, we_cyc[0]); end
        checks++; if (bus.retired !== 16'd1 || bus.err !== 1'b1) begin errors++; $display("FAIL illegal_final got retired=%0d err=%b exp 1/1", bus.retired, bus.err); end
        run(1'b0);
        checks++; if (err_c[1] !== 1'b0 || err_c[7] !== 1'b1) begin errors++; $display("FAIL illegal_clear got c1=%b c7=%b exp 0/1", err_c[1], err_c[7]); end
    endtask

    task automatic test_slt;
        bit saw111;
        mem[0] = rtype(5'd1, 5'd2, 5'd6, 6'b101010); // slt $6,$1,$2
        mem[1] = rtype(5'd1, 5'd2, 5'd3, 6'b100000);
        mem[2] = rtype(5'd1, 5'd2, 5'd4, 6'b100000);
        run(1'b0);
`ifdef DPTR_CTRL_SLT_EN
        checks++; if (alu_c[3] !== 3'b111) begin errors++; $display("FAIL slt_alu got %b exp 111", alu_c[3]); end
        checks++; if (n_we !== 3 || we_cyc[0] !== 4 || we_wa[0] !== 5'd6) begin errors++; $display("FAIL slt_we got n=%0d cyc=%0d wa=%0d exp 3/4/6", n_we, we_cyc[0], we_wa[0]); end
        checks++; if (bus.err !== 1'b0 || bus.retired !== 16'd3) begin errors++; $display("FAIL slt_final got err=%b retired=%0d exp 0/3", bus.err, bus.retired); end
`else
        saw111 = 1'b0;
        for (int c = 1; c < 64; c++) if (alu_c[c] === 3'b111) saw111 = 1'b1;
        checks++; if (err_c[3] !== 1'b1 || done_cyc !== 4) begin errors++; $display("FAIL slt_err got err=%b done=%0d exp 1/4", err_c[3], done_cyc); end
        checks++; if (n_we !== 0 || saw111 !== 1'b0) begin errors++; $display("FAIL slt_nowrite got n_we=%0d alu111=%b exp 0/0", n_we, saw111); end
        checks++; if (bus.retired !== 16'd0) begin errors++; $display("FAIL slt_retired got %0d exp 0", bus.retired); end
`endif
    endtask

    task automatic test_hold_start;
        load_basic();
        run(1'b1);
        checks++; if (n_done !== 1 || done_cyc !== 13) begin errors++; $display("FAIL hold_done got n=%0d cyc=%0d exp 1/13", n_done, done_cyc); end
        checks++; if (addr_c[5] !== 8'd1 || addr_c[9] !== 8'd2) begin errors++; $display("FAIL hold_pc got a5=%0d a9=%0d exp 1/2", addr_c[5], addr_c[9]); end
        checks++; if (busy_c[14] !== 1'b0) begin errors++; $display("FAIL hold_idle got busy=%b exp 0", busy_c[14]); end
        run(1'b0);
        checks++; if (addr_c[1] !== 8'd0 || done_cyc !== 13 || n_we !== 3) begin
            errors++; $display("FAIL relaunch got addr=%0d done=%0d n_we=%0d exp 0/13/3", addr_c[1], done_cyc, n_we);
        end
    endtask

    task automatic test_reset_mid;
        bit we_seen;
        load_basic();
        @(negedge clk); bus.start = 1'b1;
        @(posedge clk); #1; bus.start = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        // cycle 7: EXEC of sub $4,$3,$1
        checks++; if (bus.alu_sel !== 3'b110 || bus.retired !== 16'd1) begin errors++; $display("FAIL mid_pre got alu=%b retired=%0d exp 110/1", bus.alu_sel, bus.retired); end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.busy !== 1'b0 || bus.imem_addr !== 8'd0 || bus.rf_we !== 1'b0 || bus.retired !== 16'd0) begin
            errors++; $display("FAIL mid_rst got busy=%b addr=%0d we=%b retired=%0d exp 0/0/0/0", bus.busy, bus.imem_addr, bus.rf_we, bus.retired);
        end
        rst = 1'b0;
        we_seen = 1'b0;
        repeat (4) begin @(posedge clk); #1; if (bus.rf_we || bus.busy) we_seen = 1'b1; end
        checks++; if (we_seen !== 1'b0) begin errors++; $display("FAIL mid_after got activity=%b exp 0", we_seen); end
    endtask

    initial begin
        bus.start = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        test_reset();
        test_basic();
        test_nop_r0();
        test_illegal();
        test_slt();
        test_hold_start();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
